// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and constants for the IF/ID decoupling queue
package if_id_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 64;
    localparam int INST_WIDTH_DEFAULT = 32;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h00000013;

    typedef struct packed {
        logic [ADDR_WIDTH_DEFAULT-1:0] pc;
        logic [ADDR_WIDTH_DEFAULT-1:0] pc4;
        logic [INST_WIDTH_DEFAULT-1:0] inst;
        logic                          exc;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - entry storage, one write port and an asynchronous read port
module if_id_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 161,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Storage is deliberately left unreset; occupancy tracking guards stale slots.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/if_id_pipe_queue.sv
// rtl/if_id_pipe_queue.sv - first-word-fall-through instruction buffer between fetch and decode
module if_id_pipe_queue
    import if_id_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int          INST_WIDTH = INST_WIDTH_DEFAULT,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT,
    parameter int          PW         = $clog2(DEPTH),
    parameter int          CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [ADDR_WIDTH-1:0] f_pc,
    input  logic [ADDR_WIDTH-1:0] f_pc4,
    input  logic [INST_WIDTH-1:0] f_inst,
    input  logic                  f_exc,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [ADDR_WIDTH-1:0] d_pc,
    output logic [ADDR_WIDTH-1:0] d_pc4,
    output logic [INST_WIDTH-1:0] d_inst,
    output logic                  d_exc,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int ENTRY_W = 2 * ADDR_WIDTH + INST_WIDTH + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] wr_data, rd_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign f_ready = !full;
    assign d_valid = !empty;
    assign push    = f_valid & f_ready;
    assign pop     = d_valid & d_ready;

    assign wr_data = {f_pc, f_pc4, f_inst, f_exc};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Reset and flush both abandon in-flight handshakes on this edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .AW     (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~flush & ~reset),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        d_pc   = '0;
        d_pc4  = '0;
        d_inst = NOP_INST[INST_WIDTH-1:0];
        d_exc  = 1'b0;
        if (!empty) begin
            {d_pc, d_pc4, d_inst, d_exc} = rd_data;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_queue.sv
// tb/tb_if_id_pipe_queue.sv - directed vector bench for if_id_pipe_queue
module tb_if_id_pipe_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, flush, f_valid, f_ready, f_exc;
    logic [63:0] f_pc, f_pc4, d_pc, d_pc4;
    logic [31:0] f_inst, d_inst;
    logic        d_valid, d_ready, d_exc, empty, full;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_pipe_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_pc4(f_pc4),
        .f_inst(f_inst), .f_exc(f_exc),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_pc4(d_pc4),
        .d_inst(d_inst), .d_exc(d_exc),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic        rst, fl, fv, exc, dr;
        logic [63:0] pc;
        logic [31:0] inst;
        int          e_cnt;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_exc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic fl, input logic fv,
                                input logic [63:0] pc, input logic [31:0] inst,
                                input logic exc, input logic dr, input int e_cnt,
                                input logic [63:0] e_pc, input logic [31:0] e_inst,
                                input logic e_exc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.fv = fv; v.pc = pc; v.inst = inst;
        v.exc = exc; v.dr = dr; v.e_cnt = e_cnt; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_exc = e_exc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int e_cnt, input logic [63:0] e_pc,
                               input logic [31:0] e_inst, input logic e_exc);
        logic dv;
        dv = (e_cnt != 0);
        chk({tag, " count"},   64'(count),   64'(e_cnt));
        chk({tag, " d_valid"}, 64'(d_valid), 64'(dv));
        chk({tag, " empty"},   64'(empty),   64'(e_cnt == 0));
        chk({tag, " full"},    64'(full),    64'(e_cnt == 4));
        chk({tag, " f_ready"}, 64'(f_ready), 64'(e_cnt != 4));
        chk({tag, " d_pc"},    d_pc,         dv ? e_pc : 64'h0);
        chk({tag, " d_pc4"},   d_pc4,        dv ? e_pc + 64'd4 : 64'h0);
        chk({tag, " d_inst"},  64'(d_inst),  64'(dv ? e_inst : NOP));
        chk({tag, " d_exc"},   64'(d_exc),   64'(dv ? e_exc : 1'b0));
    endtask

    task automatic drive(input logic rst, input logic fl, input logic fv, input logic [63:0] pc,
                         input logic [31:0] inst, input logic exc, input logic dr);
        reset = rst; flush = fl; f_valid = fv; f_pc = pc; f_pc4 = pc + 64'd4;
        f_inst = inst; f_exc = exc; d_ready = dr;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        //  rst fl fv  pc        inst          exc dr  cnt head_pc   head_inst     exc
        add(1, 0, 0, 64'h0,    32'h0,        0, 0, 0, 64'h0,    NOP,          0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 0, 0, 64'h0,    NOP,          0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 0, 64'h0,    NOP,          0);
        add(0, 0, 1, 64'h1000, 32'h00500093, 0, 0, 1, 64'h1000, 32'h00500093, 0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 0, 64'h0,    NOP,          0);
        add(0, 0, 1, 64'h0,    32'h100,      0, 0, 1, 64'h0,    32'h100,      0);
        add(0, 0, 1, 64'h4,    32'h101,      0, 0, 2, 64'h0,    32'h100,      0);
        add(0, 0, 1, 64'h8,    32'h102,      0, 0, 3, 64'h0,    32'h100,      0);
        add(0, 0, 1, 64'hC,    32'h103,      0, 0, 4, 64'h0,    32'h100,      0);
        add(0, 0, 1, 64'h10,   32'h104,      0, 0, 4, 64'h0,    32'h100,      0);
        add(0, 0, 1, 64'h10,   32'h104,      0, 1, 3, 64'h4,    32'h101,      0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 2, 64'h8,    32'h102,      0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 1, 64'hC,    32'h103,      0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 0, 64'h0,    NOP,          0);
        add(0, 0, 1, 64'hA0,   32'h200,      0, 0, 1, 64'hA0,   32'h200,      0);
        add(0, 0, 1, 64'hA4,   32'h201,      0, 0, 2, 64'hA0,   32'h200,      0);
        add(0, 0, 1, 64'hA8,   32'h202,      0, 0, 3, 64'hA0,   32'h200,      0);
        add(0, 1, 1, 64'h2000, 32'h300,      0, 1, 0, 64'h0,    NOP,          0);
        add(0, 0, 1, 64'h2100, 32'h301,      0, 0, 1, 64'h2100, 32'h301,      0);
        add(0, 0, 1, 64'h3002, 32'h302,      1, 0, 2, 64'h2100, 32'h301,      0);
        add(0, 0, 0, 64'h0,    32'h0,        0, 1, 1, 64'h3002, 32'h302,      1);
        add(0, 0, 1, 64'h3100, 32'h303,      0, 0, 2, 64'h3002, 32'h302,      1);
        add(1, 0, 1, 64'h3200, 32'h304,      0, 1, 0, 64'h0,    NOP,          0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].fl, vecs[i].fv, vecs[i].pc, vecs[i].inst,
                  vecs[i].exc, vecs[i].dr);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_pc,
                        vecs[i].e_inst, vecs[i].e_exc);
        end

        // Prime two entries, then stream push+pop across several pointer wraps.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 64'h5000 + 64'(4 * k), 32'h5000 + 32'(k), 0, 0);
        end
        @(posedge clk);
        #1;
        check_state("prime", 2, 64'h5000, 32'h5000, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 64'h5000 + 64'(4 * (k + 2)), 32'h5000 + 32'(k + 2), 0, 1);
            @(posedge clk);
            #1;
            check_state($sformatf("stream%0d", k), 2, 64'h5000 + 64'(4 * (k + 1)),
                        32'h5000 + 32'(k + 1), 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check_state("drain0", 1, 64'h5000 + 64'(4 * 11), 32'h5000 + 32'd11, 0);
        @(posedge clk);
        #1;
        check_state("drain1", 0, 64'h0, NOP, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
